// File: rtl/dma_quiesce_pkg.sv
// dma_quiesce_pkg
// Shared definitions for the DMA drain monitor. It holds the per-channel
// state encoding, the default parameter values, and a helper that sizes the
// outstanding-burst counter.
package dma_quiesce_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      QUIET = 2'd2
   } chan_state_t;

   localparam int DEF_MAX_OUT    = 8;
   localparam int DEF_QUIET_HOLD = 4;
   localparam int DEF_TIMEOUT    = 1024;

   // Width needed to hold the values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

   localparam int DEF_CNT_W = $clog2(DEF_MAX_OUT + 1);

endpackage

// File: rtl/dma_quiesce_if.sv
// dma_quiesce_if
// Bundles the halt request, both channel handshakes, and the status outputs of
// the drain monitor.
//   master : DMA engines plus the soft-reset sequencer. They drive halt, valid
//            and cpl, and observe ready and status.
//   slave  : the drain monitor. It drives ready, quiet, the counts and the
//            sticky flags.
interface dma_quiesce_if
   import dma_quiesce_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             dma_halt;
   logic             tx_req_valid;
   logic             tx_req_ready;
   logic             tx_cpl;
   logic             rx_req_valid;
   logic             rx_req_ready;
   logic             rx_cpl;
   logic             tx_quiet;
   logic             rx_quiet;
   logic [CNT_W-1:0] tx_outstanding;
   logic [CNT_W-1:0] rx_outstanding;
   logic             drain_timeout;
   logic             cnt_err;

   modport master (
      output dma_halt, tx_req_valid, tx_cpl, rx_req_valid, rx_cpl,
      input  tx_req_ready, rx_req_ready, tx_quiet, rx_quiet,
             tx_outstanding, rx_outstanding, drain_timeout, cnt_err
   );

   modport slave (
      input  dma_halt, tx_req_valid, tx_cpl, rx_req_valid, rx_cpl,
      output tx_req_ready, rx_req_ready, tx_quiet, rx_quiet,
             tx_outstanding, rx_outstanding, drain_timeout, cnt_err
   );

endinterface

// File: rtl/dma_quiesce_chan.sv
// dma_quiesce_chan
// Drain tracker for one DMA channel. It contains the RUN/DRAIN/QUIET FSM, the
// outstanding-burst counter, the quiet hold counter and the drain timer.
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   halt          : level halt request
//   req_valid     : engine wants to issue a burst
//   req_ready     : issue grant (only from registered state and count)
//   cpl           : one-cycle completion pulse
//   quiet         : registered, high while in QUIET
//   count         : outstanding bursts
//   state         : current FSM state (used by the top-level flag clear)
//   timeout_pulse : high on the edge where the drain timer reaches TIMEOUT
//   err_pulse     : high on a completion underflow or a completion in QUIET
module dma_quiesce_chan
   import dma_quiesce_pkg::*;
#(
   parameter  int MAX_OUT    = DEF_MAX_OUT,
   parameter  int QUIET_HOLD = DEF_QUIET_HOLD,
   parameter  int TIMEOUT    = DEF_TIMEOUT,
   localparam int CNT_W      = cnt_width(MAX_OUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             halt,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             cpl,
   output logic             quiet,
   output logic [CNT_W-1:0] count,
   output chan_state_t      state,
   output logic             timeout_pulse,
   output logic             err_pulse
);

   localparam int HOLD_W = $clog2(QUIET_HOLD + 1);
   localparam int TMR_W  = $clog2(TIMEOUT + 1);

   chan_state_t       state_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic [HOLD_W-1:0] hold_reg;
   logic [TMR_W-1:0]  timer_reg;
   logic              quiet_reg;
   logic              issue;

   // Ready never looks at valid, so there is no combinational loop through
   // the engine.
   assign req_ready = (state_reg == RUN) && (count_reg < CNT_W'(MAX_OUT));
   assign issue     = req_valid && req_ready;

   always_comb begin
      count_next = count_reg;
      if (issue && !cpl) begin
         count_next = count_reg + CNT_W'(1);
      end else if (cpl && !issue && (count_reg != '0)) begin
         count_next = count_reg - CNT_W'(1);
      end
   end

   // A completion in QUIET is flagged even when the count is nonzero. QUIET
   // normally implies count 0, so in practice that case overlaps with the
   // underflow.
   assign err_pulse = cpl && ((!issue && (count_reg == '0)) || (state_reg == QUIET));

   // Fires exactly once per drain. After the timer saturates it no longer
   // equals TIMEOUT-1.
   assign timeout_pulse = (state_reg == DRAIN) && halt && (timer_reg == TMR_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         count_reg <= '0;
         hold_reg  <= '0;
         timer_reg <= '0;
         quiet_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         case (state_reg)
            RUN: begin
               hold_reg  <= '0;
               timer_reg <= '0;
               quiet_reg <= 1'b0;
               if (halt) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (!halt) begin
                  state_reg <= RUN;
                  hold_reg  <= '0;
                  timer_reg <= '0;
               end else begin
                  if (timer_reg < TMR_W'(TIMEOUT)) begin
                     timer_reg <= timer_reg + TMR_W'(1);
                  end
                  // The hold counter uses the registered count. The edge
                  // that retires the last burst still sees a nonzero count,
                  // so the hold starts counting on the edge after it.
                  if (count_reg == '0) begin
                     if (hold_reg == HOLD_W'(QUIET_HOLD - 1)) begin
                        state_reg <= QUIET;
                        quiet_reg <= 1'b1;
                     end else begin
                        hold_reg <= hold_reg + HOLD_W'(1);
                     end
                  end else begin
                     hold_reg <= '0;
                  end
               end
            end
            QUIET: begin
               if (!halt) begin
                  state_reg <= RUN;
                  quiet_reg <= 1'b0;
                  hold_reg  <= '0;
                  timer_reg <= '0;
               end
            end
            default: begin
               state_reg <= RUN;
               quiet_reg <= 1'b0;
               hold_reg  <= '0;
               timer_reg <= '0;
            end
         endcase
      end
   end

   assign quiet = quiet_reg;
   assign count = count_reg;
   assign state = state_reg;

endmodule

// File: rtl/dma_quiesce.sv
// dma_quiesce
// Per-channel DMA drain monitor. It sits between the DMA engines and the
// soft-reset sequencer. It gates new bursts while dma_halt is high, tracks
// outstanding TX/RX bursts, and reports when each channel is quiet. It also
// holds the sticky drain_timeout and cnt_err flags.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : dma_quiesce_if slave modport, which carries the halt, both
//                handshakes, the completions and all status outputs
module dma_quiesce
   import dma_quiesce_pkg::*;
#(
   parameter int MAX_OUT    = DEF_MAX_OUT,
   parameter int QUIET_HOLD = DEF_QUIET_HOLD,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input logic        clk,
   input logic        rst_n,
   dma_quiesce_if.slave bus
);

   localparam int CNT_W = cnt_width(MAX_OUT);

   chan_state_t      tx_state;
   chan_state_t      rx_state;
   logic [CNT_W-1:0] tx_count;
   logic [CNT_W-1:0] rx_count;
   logic             tx_tmo;
   logic             rx_tmo;
   logic             tx_err;
   logic             rx_err;
   logic             tx_quiet;
   logic             rx_quiet;
   logic             tx_ready;
   logic             rx_ready;
   logic             flag_clear;
   logic             drain_timeout_reg;
   logic             cnt_err_reg;

   dma_quiesce_chan #(
      .MAX_OUT    (MAX_OUT),
      .QUIET_HOLD (QUIET_HOLD),
      .TIMEOUT    (TIMEOUT)
   ) u_tx (
      .clk           (clk),
      .rst_n         (rst_n),
      .halt          (bus.dma_halt),
      .req_valid     (bus.tx_req_valid),
      .req_ready     (tx_ready),
      .cpl           (bus.tx_cpl),
      .quiet         (tx_quiet),
      .count         (tx_count),
      .state         (tx_state),
      .timeout_pulse (tx_tmo),
      .err_pulse     (tx_err)
   );

   dma_quiesce_chan #(
      .MAX_OUT    (MAX_OUT),
      .QUIET_HOLD (QUIET_HOLD),
      .TIMEOUT    (TIMEOUT)
   ) u_rx (
      .clk           (clk),
      .rst_n         (rst_n),
      .halt          (bus.dma_halt),
      .req_valid     (bus.rx_req_valid),
      .req_ready     (rx_ready),
      .cpl           (bus.rx_cpl),
      .quiet         (rx_quiet),
      .count         (rx_count),
      .state         (rx_state),
      .timeout_pulse (rx_tmo),
      .err_pulse     (rx_err)
   );

   // The flags are cleared only while the whole block is running with no
   // halt. A new event on the same edge wins over the clear, so it is never
   // lost.
   assign flag_clear = !bus.dma_halt && (tx_state == RUN) && (rx_state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_timeout_reg <= 1'b0;
         cnt_err_reg       <= 1'b0;
      end else begin
         if (tx_tmo || rx_tmo) begin
            drain_timeout_reg <= 1'b1;
         end else if (flag_clear) begin
            drain_timeout_reg <= 1'b0;
         end
         if (tx_err || rx_err) begin
            cnt_err_reg <= 1'b1;
         end else if (flag_clear) begin
            cnt_err_reg <= 1'b0;
         end
      end
   end

   assign bus.tx_req_ready   = tx_ready;
   assign bus.rx_req_ready   = rx_ready;
   assign bus.tx_quiet       = tx_quiet;
   assign bus.rx_quiet       = rx_quiet;
   assign bus.tx_outstanding = tx_count;
   assign bus.rx_outstanding = rx_count;
   assign bus.drain_timeout  = drain_timeout_reg;
   assign bus.cnt_err        = cnt_err_reg;

endmodule

// File: tb/tb_dma_quiesce.sv
module tb_dma_quiesce;
   import dma_quiesce_pkg::*;

   localparam int CNT_W = 4;

   logic clk;
   logic rst_n;
   int   pass_count;
   int   total_count;
   int   tx_model;
   int   rx_model;
   int   exp_q[$];
   int   exp_val;

   dma_quiesce_if #(.CNT_W(CNT_W)) bus ();

   dma_quiesce #(
      .MAX_OUT    (8),
      .QUIET_HOLD (4),
      .TIMEOUT    (1024)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.dma_halt = 1'b0;
      bus.tx_req_valid = 1'b0;
      bus.tx_cpl = 1'b0;
      bus.rx_req_valid = 1'b0;
      bus.rx_cpl = 1'b0;
      tx_model = 0;
      rx_model = 0;
      #2;
      total_count++;
      if ({bus.tx_quiet, bus.rx_quiet, bus.drain_timeout, bus.cnt_err} !== 4'b0000)
         $display("FAIL reset_flags: got %b expected 0000",
                  {bus.tx_quiet, bus.rx_quiet, bus.drain_timeout, bus.cnt_err});
      else pass_count++;
      total_count++;
      if (bus.tx_outstanding !== 4'd0 || bus.rx_outstanding !== 4'd0)
         $display("FAIL reset_counts: got tx=%0d rx=%0d expected 0/0",
                  bus.tx_outstanding, bus.rx_outstanding);
      else pass_count++;
      total_count++;
      if (bus.tx_req_ready !== 1'b1 || bus.rx_req_ready !== 1'b1)
         $display("FAIL reset_ready: got tx=%b rx=%b expected 1/1",
                  bus.tx_req_ready, bus.rx_req_ready);
      else pass_count++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_idle_halt();
      bus.dma_halt = 1'b1;
      tick();  // edge N samples the halt
      total_count++;
      if (bus.tx_req_ready !== 1'b0 || bus.rx_req_ready !== 1'b0)
         $display("FAIL idle_ready_low: got tx=%b rx=%b expected 0/0",
                  bus.tx_req_ready, bus.rx_req_ready);
      else pass_count++;
      repeat (3) tick();  // N+3
      total_count++;
      if (bus.tx_quiet !== 1'b0 || bus.rx_quiet !== 1'b0)
         $display("FAIL idle_quiet_early: got tx=%b rx=%b expected 0/0",
                  bus.tx_quiet, bus.rx_quiet);
      else pass_count++;
      tick();  // N+4
      total_count++;
      if (bus.tx_quiet !== 1'b1 || bus.rx_quiet !== 1'b1)
         $display("FAIL idle_quiet: got tx=%b rx=%b expected 1/1",
                  bus.tx_quiet, bus.rx_quiet);
      else pass_count++;
      bus.dma_halt = 1'b0;
      tick();  // K
      total_count++;
      if ({bus.tx_quiet, bus.rx_quiet, bus.tx_req_ready, bus.rx_req_ready} !== 4'b0011)
         $display("FAIL idle_release: got %b expected 0011",
                  {bus.tx_quiet, bus.rx_quiet, bus.tx_req_ready, bus.rx_req_ready});
      else pass_count++;
   endtask

   task automatic test_drain();
      bus.tx_req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tx_model++;
         exp_q.push_back(tx_model);
         tick();
         exp_val = exp_q.pop_front();
         $display("txn drain_issue tx_outstanding=%0d exp=%0d", bus.tx_outstanding, exp_val);
         total_count++;
         if (bus.tx_outstanding !== CNT_W'(exp_val))
            $display("FAIL drain_issue: got %0d expected %0d", bus.tx_outstanding, exp_val);
         else pass_count++;
      end
      bus.tx_req_valid = 1'b0;
      bus.dma_halt = 1'b1;
      tick();  // N
      for (int c = 0; c < 3; c++) begin
         repeat (4) tick();
         if (c == 0) begin
            total_count++;
            if (bus.rx_quiet !== 1'b1 || bus.tx_quiet !== 1'b0)
               $display("FAIL drain_rx_quiet: got rx=%b tx=%b expected 1/0",
                        bus.rx_quiet, bus.tx_quiet);
            else pass_count++;
         end
         bus.tx_cpl = 1'b1;
         tx_model--;
         exp_q.push_back(tx_model);
         tick();  // completions at N+5, N+10, N+15
         bus.tx_cpl = 1'b0;
         exp_val = exp_q.pop_front();
         $display("txn drain_cpl tx_outstanding=%0d exp=%0d", bus.tx_outstanding, exp_val);
         total_count++;
         if (bus.tx_outstanding !== CNT_W'(exp_val))
            $display("FAIL drain_cpl: got %0d expected %0d", bus.tx_outstanding, exp_val);
         else pass_count++;
      end
      repeat (3) tick();  // M+3
      total_count++;
      if (bus.tx_quiet !== 1'b0)
         $display("FAIL drain_tx_quiet_early: got %b expected 0", bus.tx_quiet);
      else pass_count++;
      tick();  // M+4
      total_count++;
      if (bus.tx_quiet !== 1'b1)
         $display("FAIL drain_tx_quiet: got %b expected 1", bus.tx_quiet);
      else pass_count++;
      // A completion in QUIET is a protocol violation, but the state holds.
      bus.tx_cpl = 1'b1;
      exp_q.push_back(0);
      tick();
      bus.tx_cpl = 1'b0;
      exp_val = exp_q.pop_front();
      total_count++;
      if (bus.cnt_err !== 1'b1 || bus.tx_quiet !== 1'b1 || bus.tx_outstanding !== CNT_W'(exp_val))
         $display("FAIL quiet_cpl_err: got err=%b quiet=%b cnt=%0d expected 1/1/%0d",
                  bus.cnt_err, bus.tx_quiet, bus.tx_outstanding, exp_val);
      else pass_count++;
      tick();
      total_count++;
      if (bus.cnt_err !== 1'b1)
         $display("FAIL quiet_err_sticky: got %b expected 1", bus.cnt_err);
      else pass_count++;
      bus.dma_halt = 1'b0;
      tick();  // K: both channels return to RUN
      tick();  // K+1: flags clear
      total_count++;
      if (bus.cnt_err !== 1'b0 || bus.tx_req_ready !== 1'b1)
         $display("FAIL drain_release: got err=%b ready=%b expected 0/1",
                  bus.cnt_err, bus.tx_req_ready);
      else pass_count++;
   endtask

   task automatic test_simultaneous();
      bus.tx_req_valid = 1'b1;
      repeat (2) begin
         tx_model++;
         tick();
      end
      bus.tx_cpl = 1'b1;  // issue and completion together at count 2
      exp_q.push_back(tx_model);
      tick();
      bus.tx_cpl = 1'b0;
      exp_val = exp_q.pop_front();
      $display("txn simul tx_outstanding=%0d exp=%0d", bus.tx_outstanding, exp_val);
      total_count++;
      if (bus.tx_outstanding !== CNT_W'(exp_val) || bus.cnt_err !== 1'b0)
         $display("FAIL simul_issue_cpl: got cnt=%0d err=%b expected %0d/0",
                  bus.tx_outstanding, bus.cnt_err, exp_val);
      else pass_count++;
      for (int i = 0; i < 8; i++) begin
         if (tx_model < 8) tx_model++;
         exp_q.push_back(tx_model);
         tick();
         exp_val = exp_q.pop_front();
         $display("txn fill tx_outstanding=%0d exp=%0d", bus.tx_outstanding, exp_val);
         total_count++;
         if (bus.tx_outstanding !== CNT_W'(exp_val))
            $display("FAIL fill_count: got %0d expected %0d", bus.tx_outstanding, exp_val);
         else pass_count++;
      end
      total_count++;
      if (bus.tx_req_ready !== 1'b0 || bus.cnt_err !== 1'b0)
         $display("FAIL full_ready: got ready=%b err=%b expected 0/0",
                  bus.tx_req_ready, bus.cnt_err);
      else pass_count++;
      bus.tx_req_valid = 1'b0;
      bus.tx_cpl = 1'b1;
      repeat (8) begin
         tx_model--;
         tick();
      end
      bus.tx_cpl = 1'b0;
      total_count++;
      if (bus.tx_outstanding !== CNT_W'(tx_model) || bus.cnt_err !== 1'b0)
         $display("FAIL empty_back: got cnt=%0d err=%b expected %0d/0",
                  bus.tx_outstanding, bus.cnt_err, tx_model);
      else pass_count++;
   endtask

   task automatic test_errors();
      bus.rx_cpl = 1'b1;
      tick();
      bus.rx_cpl = 1'b0;
      total_count++;
      if (bus.cnt_err !== 1'b1 || bus.rx_outstanding !== 4'd0)
         $display("FAIL underflow: got err=%b cnt=%0d expected 1/0",
                  bus.cnt_err, bus.rx_outstanding);
      else pass_count++;
      tick();  // halt low with both channels in RUN clears the flag
      total_count++;
      if (bus.cnt_err !== 1'b0)
         $display("FAIL err_clear_run: got %b expected 0", bus.cnt_err);
      else pass_count++;
   endtask

   task automatic test_timeout();
      bus.tx_req_valid = 1'b1;
      tx_model++;
      tick();
      bus.tx_req_valid = 1'b0;
      bus.dma_halt = 1'b1;
      tick();  // N
      repeat (1023) tick();
      total_count++;
      if (bus.drain_timeout !== 1'b0)
         $display("FAIL timeout_early: got %b expected 0", bus.drain_timeout);
      else pass_count++;
      tick();  // N+1024
      total_count++;
      if (bus.drain_timeout !== 1'b1 || bus.tx_quiet !== 1'b0 || bus.rx_quiet !== 1'b1)
         $display("FAIL timeout_set: got tmo=%b txq=%b rxq=%b expected 1/0/1",
                  bus.drain_timeout, bus.tx_quiet, bus.rx_quiet);
      else pass_count++;
      bus.dma_halt = 1'b0;
      tick();  // K
      total_count++;
      if (bus.tx_req_ready !== 1'b1 || bus.drain_timeout !== 1'b1)
         $display("FAIL timeout_release: got ready=%b tmo=%b expected 1/1",
                  bus.tx_req_ready, bus.drain_timeout);
      else pass_count++;
      tick();
      total_count++;
      if (bus.drain_timeout !== 1'b0)
         $display("FAIL timeout_clear: got %b expected 0", bus.drain_timeout);
      else pass_count++;
      bus.tx_cpl = 1'b1;
      tx_model--;
      exp_q.push_back(tx_model);
      tick();
      bus.tx_cpl = 1'b0;
      exp_val = exp_q.pop_front();
      $display("txn timeout_cpl tx_outstanding=%0d exp=%0d", bus.tx_outstanding, exp_val);
      total_count++;
      if (bus.tx_outstanding !== CNT_W'(exp_val))
         $display("FAIL timeout_cpl: got %0d expected %0d", bus.tx_outstanding, exp_val);
      else pass_count++;
   endtask

   task automatic test_reset_mid_drain();
      bus.tx_req_valid = 1'b1;
      repeat (5) begin
         tx_model++;
         tick();
      end
      bus.tx_req_valid = 1'b0;
      bus.dma_halt = 1'b1;
      tick();
      tick();
      bus.rx_cpl = 1'b1;  // underflow in DRAIN, flag is held under halt
      tick();
      bus.rx_cpl = 1'b0;
      total_count++;
      if (bus.tx_outstanding !== CNT_W'(tx_model) || bus.cnt_err !== 1'b1)
         $display("FAIL pre_reset: got cnt=%0d err=%b expected %0d/1",
                  bus.tx_outstanding, bus.cnt_err, tx_model);
      else pass_count++;
      #2;
      rst_n = 1'b0;  // mid-cycle, no clock edge involved
      tx_model = 0;
      #1;
      total_count++;
      if (bus.tx_outstanding !== CNT_W'(tx_model) || bus.cnt_err !== 1'b0 ||
          bus.drain_timeout !== 1'b0 || bus.tx_quiet !== 1'b0 || bus.tx_req_ready !== 1'b1)
         $display("FAIL async_reset: got cnt=%0d err=%b tmo=%b q=%b rdy=%b expected 0/0/0/0/1",
                  bus.tx_outstanding, bus.cnt_err, bus.drain_timeout,
                  bus.tx_quiet, bus.tx_req_ready);
      else pass_count++;
      bus.dma_halt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.tx_cpl = 1'b1;  // completion still in flight from before the reset
      exp_q.push_back(0);
      tick();
      bus.tx_cpl = 1'b0;
      exp_val = exp_q.pop_front();
      $display("txn post_reset_cpl tx_outstanding=%0d exp=%0d", bus.tx_outstanding, exp_val);
      total_count++;
      if (bus.cnt_err !== 1'b1 || bus.tx_outstanding !== CNT_W'(exp_val))
         $display("FAIL post_reset_underflow: got err=%b cnt=%0d expected 1/%0d",
                  bus.cnt_err, bus.tx_outstanding, exp_val);
      else pass_count++;
   endtask

   initial begin
      pass_count  = 0;
      total_count = 0;
      test_reset();
      test_idle_halt();
      test_drain();
      test_simultaneous();
      test_errors();
      test_timeout();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
